// File: rtl/pp_combine_pipe_if.sv
// Handshake and payload bundle for pp_combine_pipe: partial-product input beat and combined result.
interface pp_combine_pipe_if #(
    parameter int unsigned HALF_W = 8,
    parameter int unsigned TAG_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_approx;
    logic [TAG_W-1:0]      in_tag;
    logic [2*HALF_W-1:0]   ll;
    logic [2*HALF_W-1:0]   lh;
    logic [2*HALF_W-1:0]   hl;
    logic [2*HALF_W-1:0]   hh;
    logic                  out_valid;
    logic                  out_ready;
    logic [TAG_W-1:0]      out_tag;
    logic [4*HALF_W-1:0]   result;

    // Environment side: produces partial products, consumes results.
    modport master (
        output in_valid, in_approx, in_tag, ll, lh, hl, hh, out_ready,
        input  in_ready, out_valid, out_tag, result
    );

    // Combiner side.
    modport slave (
        input  in_valid, in_approx, in_tag, ll, lh, hl, hh, out_ready,
        output in_ready, out_valid, out_tag, result
    );
endinterface

// File: rtl/pp_combine_pipe.sv
// Two-stage pipelined combiner of four HALF_W x HALF_W partial products into a 4*HALF_W product,
// with valid/ready backpressure and per-beat exact/approximate mode.
module pp_combine_pipe #(
    parameter int unsigned HALF_W   = 8,
    parameter int unsigned APPROX_K = 4,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pp_combine_pipe_if.slave bus
);
    localparam int unsigned PW = 2 * HALF_W;
    localparam int unsigned RW = 4 * HALF_W;
    localparam int unsigned MW = PW + 2;

    // One spare bit lets APPROX_K == PW clear every bit of the operand.
    localparam logic [PW:0]   KeepWide = {(PW + 1){1'b1}} << APPROX_K;
    localparam logic [PW-1:0] KeepMask = KeepWide[PW-1:0];

    if (APPROX_K > 2 * HALF_W || HALF_W < 2) begin : g_bad_params
        $error("pp_combine_pipe: illegal HALF_W/APPROX_K combination");
    end

    logic                  advance;
    logic [PW-1:0]         lh_m;
    logic [PW-1:0]         hl_m;
    logic [MW-1:0]         m_d;
    logic [RW-1:0]         result_d;

    logic                  s1_valid_q;
    logic [HALF_W-1:0]     s1_ll_lo_q;
    logic [MW-1:0]         s1_m_q;
    logic [PW-1:0]         s1_hh_q;
    logic [TAG_W-1:0]      s1_tag_q;

    logic                  out_valid_q;
    logic [RW-1:0]         result_q;
    logic [TAG_W-1:0]      out_tag_q;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        lh_m = bus.lh;
        hl_m = bus.hl;
        if (bus.in_approx) begin
            lh_m = bus.lh & KeepMask;
            hl_m = bus.hl & KeepMask;
        end
        m_d = MW'(bus.ll[PW-1:HALF_W]) + MW'(lh_m) + MW'(hl_m);
    end

    always_comb begin
        result_d = {s1_hh_q, {PW{1'b0}}} + RW'({s1_m_q, {HALF_W{1'b0}}}) + RW'(s1_ll_lo_q);
    end

    // Whole pipe moves together; a bubble in stage 1 becomes a bubble at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ll_lo_q  <= '0;
            s1_m_q      <= '0;
            s1_hh_q     <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else if (advance) begin
            s1_valid_q  <= bus.in_valid;
            out_valid_q <= s1_valid_q;
            if (bus.in_valid) begin
                s1_ll_lo_q <= bus.ll[HALF_W-1:0];
                s1_m_q     <= m_d;
                s1_hh_q    <= bus.hh;
                s1_tag_q   <= bus.in_tag;
            end
            if (s1_valid_q) begin
                result_q  <= result_d;
                out_tag_q <= s1_tag_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_pp_combine_pipe.sv
// Randomized self-checking bench for pp_combine_pipe against an arithmetic reference model.
module tb_pp_combine_pipe;
    localparam int unsigned HALF_W   = 8;
    localparam int unsigned APPROX_K = 4;
    localparam int unsigned TAG_W    = 4;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      model;
        logic             has_gold;
        logic [31:0]      gold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc   = 0;
    logic rand_done;

    always #5 clk = ~clk;

    pp_combine_pipe_if #(.HALF_W(HALF_W), .TAG_W(TAG_W)) bus ();

    pp_combine_pipe #(
        .HALF_W  (HALF_W),
        .APPROX_K(APPROX_K),
        .TAG_W   (TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Full product from the four sub-products; approximate mode drops the low K bits of lh/hl.
    function automatic logic [31:0] ref_combine(input logic [15:0] ll, input logic [15:0] lh,
                                                input logic [15:0] hl, input logic [15:0] hh,
                                                input logic ap);
        longint unsigned mask;
        longint unsigned sum;
        mask = ap ? ~((64'd1 << APPROX_K) - 64'd1) : ~64'd0;
        sum = {48'd0, ll}
            + ((({48'd0, lh} & mask) + ({48'd0, hl} & mask)) << HALF_W)
            + ({48'd0, hh} << (2 * HALF_W));
        return sum[31:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: every result transfer must match the oldest outstanding beat.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                check("model", 64'(bus.result), 64'(e.model));
                if (e.has_gold) check("gold", 64'(bus.result), 64'(e.gold));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the transferring edge.
    task automatic send(input logic [15:0] ll, input logic [15:0] lh, input logic [15:0] hl,
                        input logic [15:0] hh, input logic ap, input logic [TAG_W-1:0] tg,
                        input logic has_gold, input logic [31:0] gold);
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.ll        = ll;
        bus.lh        = lh;
        bus.hl        = hl;
        bus.hh        = hh;
        bus.in_approx = ap;
        bus.in_tag    = tg;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                #1;
                e.tag      = tg;
                e.model    = ref_combine(ll, lh, hl, hh, ap);
                e.has_gold = has_gold;
                e.gold     = gold;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 64'd1, 64'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic ap, input logic [TAG_W-1:0] tg);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        send(16'(a[7:0]) * 16'(b[7:0]), 16'(a[7:0]) * 16'(b[15:8]),
             16'(a[15:8]) * 16'(b[7:0]), 16'(a[15:8]) * 16'(b[15:8]),
             ap, tg, !ap, 32'(a) * 32'(b));
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int o0;
        logic [31:0] held_res;
        logic [TAG_W-1:0] held_tag;

        bus.in_valid  = 1'b0;
        bus.in_approx = 1'b0;
        bus.in_tag    = '0;
        bus.ll        = '0;
        bus.lh        = '0;
        bus.hl        = '0;
        bus.hh        = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Small exact product with latency and single-cycle valid pulse.
        send(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 4'd1, 1'b1, 32'h0004_0501);
        @(negedge clk);
        check("lat_stage1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        check("lat_pulse", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 1'b0, 4'd2, 1'b1, 32'hFFFE_0001);
        send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 1'b1, 4'd3, 1'b1, 32'hFFFD_FE01);
        drain();

        // Mixed mode back-to-back.
        for (int i = 0; i < 6; i++) begin
            send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, i[0], TAG_W'(i), 1'b1,
                 i[0] ? 32'hFFFD_FE01 : 32'hFFFE_0001);
        end
        drain();

        // Backpressure: stall the consumer for three cycles after the first result.
        fork
            begin
                for (int t = 1; t <= 4; t++) send_rand(1'b0, TAG_W'(t));
            end
            begin
                for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_valid", 64'(bus.out_valid), 64'd1);
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                held_res = bus.result;
                held_tag = bus.out_tag;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_in_ready_hold", 64'(bus.in_ready), 64'd0);
                    check("bp_result_hold", 64'(bus.result), 64'(held_res));
                    check("bp_tag_hold", 64'(bus.out_tag), 64'(held_tag));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Full throughput with random consistent beats.
        t0 = cyc;
        o0 = n_out;
        for (int i = 0; i < 100; i++) send_rand(1'($urandom_range(0, 1)), TAG_W'(i));
        check("thru_cycles", 64'(cyc - t0), 64'd100);
        drain();
        check("thru_count", 64'(n_out - o0), 64'd100);

        // Random input gaps and consumer stalls.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_rand(1'($urandom_range(0, 1)), TAG_W'(i));
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                for (int i = 0; i < 2000 && !rand_done; i++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset with two beats in flight.
        send_rand(1'b0, 4'd5);
        send_rand(1'b1, 4'd6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_tag", 64'(bus.out_tag), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o0 = n_out;
        send(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 4'd9, 1'b1, 32'h0004_0501);
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_count", 64'(n_out - o0), 64'd1);
        check("leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
